// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared state, stage encodings and board constants for the Sudoku game sequencer
package sudoku_pkg;

    localparam int BOARD_DIM = 9;
    localparam int CELL_CNT  = 81;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] COORD_MAX = 4'(BOARD_DIM - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_WRITE,
        ST_SOLVE,
        ST_SHOW
    } game_state_t;

    localparam logic [1:0] STAGE_IDLE  = 2'd0;
    localparam logic [1:0] STAGE_PLAY  = 2'd1;
    localparam logic [1:0] STAGE_SOLVE = 2'd2;
    localparam logic [1:0] STAGE_SHOW  = 2'd3;

    // WRITE is a transient sub-step of play, so the screen keeps showing the board
    function automatic logic [1:0] stage_of(input game_state_t s);
        case (s)
            ST_PLAY, ST_WRITE: stage_of = STAGE_PLAY;
            ST_SOLVE:          stage_of = STAGE_SOLVE;
            ST_SHOW:           stage_of = STAGE_SHOW;
            default:           stage_of = STAGE_IDLE;
        endcase
    endfunction

    function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
        cell_index = {3'b000, row} * 7'd9 + {3'b000, col};
    endfunction

endpackage

// File: rtl/sudoku_cursor.sv
// rtl/sudoku_cursor.sv - saturating 9x9 cell cursor driven by one-cycle move pulses
module sudoku_cursor
    import sudoku_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic [3:0] row,
    output logic [3:0] col
);

    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;

    // next cursor: clear wins, opposite moves cancel, edges saturate
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (up && !down && row_q != 4'd0) begin
                row_d = row_q - 4'd1;
            end else if (down && !up && row_q != COORD_MAX) begin
                row_d = row_q + 4'd1;
            end
            if (left && !right && col_q != 4'd0) begin
                col_d = col_q - 4'd1;
            end else if (right && !left && col_q != COORD_MAX) begin
                col_d = col_q + 4'd1;
            end
        end
    end

    // cursor registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/sudoku_game_ctrl.sv
// rtl/sudoku_game_ctrl.sv - game sequencer (cursor, solver writes, check launch, timeout under SOLVE_TIMEOUT_EN)
module sudoku_game_ctrl
    import sudoku_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ev_start,
    input  logic                ev_enter,
    input  logic                ev_up,
    input  logic                ev_down,
    input  logic                ev_left,
    input  logic                ev_right,
    input  logic                digit_valid,
    input  logic [3:0]          digit,
    input  logic [CELL_CNT-1:0] init_blank,
    input  logic                sol_done,
    input  logic                sol_valid,
    output logic [3:0]          cursor_row,
    output logic [3:0]          cursor_col,
    output logic                sol_read,
    output logic [3:0]          sol_row,
    output logic [3:0]          sol_col,
    output logic [3:0]          sol_data,
    output logic                sol_start,
    output logic [1:0]          stage,
    output logic                result_ok,
    output logic                timed_out
);

    game_state_t state_q, state_d;
    logic [1:0]  stage_q, stage_d;
    logic [3:0]  sol_row_q, sol_row_d;
    logic [3:0]  sol_col_q, sol_col_d;
    logic [3:0]  sol_data_q, sol_data_d;
    logic        sol_read_q, sol_read_d;
    logic        sol_start_q, sol_start_d;
    logic        result_ok_q, result_ok_d;
    logic        move_en;
    logic        digit_ok;
    logic        expire;

    assign digit_ok = digit_valid && (digit <= DIGIT_MAX)
                      && init_blank[cell_index(cursor_row, cursor_col)];

    // next state, write latch, strobes and verdict
    always_comb begin
        state_d     = state_q;
        sol_row_d   = sol_row_q;
        sol_col_d   = sol_col_q;
        sol_data_d  = sol_data_q;
        sol_read_d  = 1'b0;
        sol_start_d = 1'b0;
        result_ok_d = result_ok_q;
        move_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ev_start) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (ev_start) begin
                    // launch wins; any digit or move in the same cycle is dropped
                    state_d     = ST_SOLVE;
                    sol_start_d = 1'b1;
                end else begin
                    move_en = 1'b1;
                    if (digit_ok) begin
                        // latch the pre-move position; the cursor moves in parallel
                        state_d    = ST_WRITE;
                        sol_row_d  = cursor_row;
                        sol_col_d  = cursor_col;
                        sol_data_d = digit;
                        sol_read_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_PLAY;
            end
            ST_SOLVE: begin
                if (sol_done) begin
                    state_d     = ST_SHOW;
                    result_ok_d = sol_valid;
                end else if (expire) begin
                    state_d     = ST_SHOW;
                    result_ok_d = 1'b0;
                end
            end
            ST_SHOW: begin
                if (ev_start) begin
                    state_d = ST_IDLE;
                end else if (ev_enter) begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_IDLE) result_ok_d = 1'b0;
    end

    assign stage_d = stage_of(state_d);

    // state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stage_q     <= STAGE_IDLE;
            sol_row_q   <= '0;
            sol_col_q   <= '0;
            sol_data_q  <= '0;
            sol_read_q  <= 1'b0;
            sol_start_q <= 1'b0;
            result_ok_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            sol_row_q   <= sol_row_d;
            sol_col_q   <= sol_col_d;
            sol_data_q  <= sol_data_d;
            sol_read_q  <= sol_read_d;
            sol_start_q <= sol_start_d;
            result_ok_q <= result_ok_d;
        end
    end

`ifdef SOLVE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out_q, timed_out_d;

    assign expire = (state_q == ST_SOLVE) && (cnt_q == CNT_LAST);

    // counter only runs inside SOLVE so each check starts from zero
    always_comb begin
        cnt_d       = (state_q == ST_SOLVE) ? cnt_q + 1'b1 : '0;
        timed_out_d = timed_out_q;
        if (state_d == ST_IDLE) begin
            timed_out_d = 1'b0;
        end else if (state_q == ST_SOLVE && state_d == ST_SHOW) begin
            timed_out_d = !sol_done;
        end
    end

    // timeout counter and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign timed_out = timed_out_q;
`else
    assign expire    = 1'b0;
    assign timed_out = 1'b0;
`endif

    sudoku_cursor u_cursor (
        .clk   (clk),
        .rst   (rst),
        .en    (move_en),
        .clr   (state_d == ST_IDLE),
        .up    (ev_up),
        .down  (ev_down),
        .left  (ev_left),
        .right (ev_right),
        .row   (cursor_row),
        .col   (cursor_col)
    );

    assign stage     = stage_q;
    assign sol_read  = sol_read_q;
    assign sol_row   = sol_row_q;
    assign sol_col   = sol_col_q;
    assign sol_data  = sol_data_q;
    assign sol_start = sol_start_q;
    assign result_ok = result_ok_q;

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// tb/tb_sudoku_game_ctrl.sv - scoreboard bench for sudoku_game_ctrl (timeout cases under SOLVE_TIMEOUT_EN)
module tb_sudoku_game_ctrl;

    localparam int TCYC = 16;
`ifdef SOLVE_TIMEOUT_EN
    localparam int VERDICT_WAIT = 8;
`else
    localparam int VERDICT_WAIT = 50;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ev_start = 1'b0, ev_enter = 1'b0;
    logic        ev_up = 1'b0, ev_down = 1'b0, ev_left = 1'b0, ev_right = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic [80:0] init_blank;
    logic        sol_done = 1'b0, sol_valid = 1'b0;
    logic [3:0]  cursor_row, cursor_col, sol_row, sol_col, sol_data;
    logic        sol_read, sol_start, result_ok, timed_out;
    logic [1:0]  stage;

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        logic [3:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  starts_seen = 0;
    int  starts_exp = 0;
    int  mrow = 0;
    int  mcol = 0;
    int  waited;

    sudoku_game_ctrl #(.TIMEOUT_CYCLES(TCYC)) dut (
        .clk(clk), .rst(rst), .ev_start(ev_start), .ev_enter(ev_enter),
        .ev_up(ev_up), .ev_down(ev_down), .ev_left(ev_left), .ev_right(ev_right),
        .digit_valid(digit_valid), .digit(digit), .init_blank(init_blank),
        .sol_done(sol_done), .sol_valid(sol_valid),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .sol_read(sol_read),
        .sol_row(sol_row), .sol_col(sol_col), .sol_data(sol_data),
        .sol_start(sol_start), .stage(stage), .result_ok(result_ok), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin : mon
        wr_t w;
        if (!rst && sol_read) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("wr_row", sol_row, w.row);
                check("wr_col", sol_col, w.col);
                check("wr_data", sol_data, w.data);
            end
        end
        if (!rst && sol_start) starts_seen++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic step_move(input logic u, input logic d, input logic l, input logic r);
        ev_up = u; ev_down = d; ev_left = l; ev_right = r;
        if (u && !d && mrow > 0) mrow--;
        else if (d && !u && mrow < 8) mrow++;
        if (l && !r && mcol > 0) mcol--;
        else if (r && !l && mcol < 8) mcol++;
        tick();
        ev_up = 0; ev_down = 0; ev_left = 0; ev_right = 0;
    endtask

    task automatic digit_in(input logic [3:0] dv, input bit accept);
        digit_valid = 1'b1;
        digit = dv;
        if (accept) exp_q.push_back('{row: 4'(mrow), col: 4'(mcol), data: dv});
        tick();
        digit_valid = 1'b0;
        tick();
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_row"}, cursor_row, mrow);
        check({tag, "_col"}, cursor_col, mcol);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_stage"}, stage, 0);
        check({tag, "_row"}, cursor_row, 0);
        check({tag, "_col"}, cursor_col, 0);
        check({tag, "_solrc"}, {sol_row, sol_col, sol_data}, 0);
        check({tag, "_strobes"}, {sol_read, sol_start}, 0);
        check({tag, "_flags"}, {result_ok, timed_out}, 0);
    endtask

    initial begin
        init_blank = {81{1'b1}};
        init_blank[50] = 1'b0;

        // reset and start
        tick(2);
        check_reset_vals("in_reset");
        rst = 1'b0;
        tick();
        check_reset_vals("after_reset");
        ev_start = 1; tick(); ev_start = 0;
        check("start_stage", stage, 1);
        check("start_no_sol_start", sol_start, 0);
        check_cursor("start_cursor");

        // editable write at (3,4)
        repeat (3) step_move(0, 1, 0, 0);
        repeat (4) step_move(0, 0, 0, 1);
        check_cursor("at_3_4");
        digit_valid = 1; digit = 4'd7;
        exp_q.push_back('{row: 4'd3, col: 4'd4, data: 4'd7});
        tick();
        digit_valid = 0;
        check("write_strobe", sol_read, 1);
        check("write_stage", stage, 1);
        tick();
        check("write_strobe_end", sol_read, 0);

        // rejected writes: out-of-range digit, then a fixed cell
        digit_in(4'd12, 0);
        check("reject_big_stage", stage, 1);
        repeat (2) step_move(0, 1, 0, 0);
        step_move(0, 0, 0, 1);
        check_cursor("at_5_5");
        digit_in(4'd3, 0);
        check("reject_fixed_stage", stage, 1);

        // saturation and cancelling moves
        repeat (10) step_move(0, 0, 0, 1);
        check("sat_right", cursor_col, 8);
        repeat (10) step_move(1, 0, 0, 0);
        check("sat_up", cursor_row, 0);
        repeat (2) step_move(0, 1, 0, 0);
        repeat (6) step_move(0, 0, 1, 0);
        check_cursor("at_2_2");
        step_move(1, 1, 1, 1);
        check_cursor("cancel");

        // digit with simultaneous move writes the pre-move cell
        digit_valid = 1; digit = 4'd5;
        exp_q.push_back('{row: 4'd2, col: 4'd2, data: 4'd5});
        ev_down = 1; mrow = 3;
        tick();
        digit_valid = 0; ev_down = 0;
        tick();
        check_cursor("digit_and_move");

        // a digit arriving in the WRITE cycle is lost
        digit_valid = 1; digit = 4'd4;
        exp_q.push_back('{row: 4'd3, col: 4'd2, data: 4'd4});
        tick();
        digit = 4'd6;
        tick();
        digit_valid = 0;
        tick();

        // solve with verdict
        starts_exp++;
        ev_start = 1; tick(); ev_start = 0;
        check("solve_start_pulse", sol_start, 1);
        check("solve_stage", stage, 2);
        tick();
        check("solve_start_end", sol_start, 0);
        tick(VERDICT_WAIT - 1);
        sol_done = 1; sol_valid = 1;
        tick();
        sol_done = 0; sol_valid = 0;
        check("verdict_stage", stage, 3);
        check("verdict_ok", result_ok, 1);
        check("verdict_no_timeout", timed_out, 0);
        ev_enter = 1; tick(); ev_enter = 0;
        check("enter_stage", stage, 1);
        check_cursor("enter_cursor");

        // second solve: digit with start dropped, move in SOLVE ignored
        starts_exp++;
        ev_start = 1; digit_valid = 1; digit = 4'd1; tick();
        ev_start = 0; digit_valid = 0;
        waited = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 1) ev_right = 1;
            tick();
            ev_right = 0;
            waited = n;
            if (stage == 2'd3) break;
        end
`ifdef SOLVE_TIMEOUT_EN
        check("timeout_cycles", waited, TCYC);
        check("timeout_stage", stage, 3);
        check("timeout_flag", timed_out, 1);
        check("timeout_result", result_ok, 0);
`else
        check("no_timeout_stage", stage, 2);
        sol_done = 1; sol_valid = 0;
        tick();
        sol_done = 0;
        check("bad_verdict_stage", stage, 3);
        check("bad_verdict_ok", result_ok, 0);
        check("bad_verdict_flag", timed_out, 0);
`endif
        check_cursor("solve_cursor_kept");

        // SHOW with both buttons goes to IDLE
        ev_start = 1; ev_enter = 1; tick(); ev_start = 0; ev_enter = 0;
        mrow = 0; mcol = 0;
        check("show_to_idle", stage, 0);
        check("idle_flags", {result_ok, timed_out}, 0);
        check_cursor("idle_cursor");

        // reset during WRITE
        ev_start = 1; tick(); ev_start = 0;
        step_move(0, 1, 0, 0);
        digit_valid = 1; digit = 4'd9;
        exp_q.push_back('{row: 4'd1, col: 4'd0, data: 4'd9});
        tick();
        digit_valid = 0;
        #2 rst = 1;
        #1 check_reset_vals("rst_in_write");
        @(posedge clk);
        tick();
        rst = 0;
        tick();
        check("rst_write_stage", stage, 0);
        mrow = 0; mcol = 0;

        // reset during SOLVE
        ev_start = 1; tick(); ev_start = 0;
        starts_exp++;
        ev_start = 1; tick(); ev_start = 0;
        tick(3);
        #2 rst = 1;
        #1 check_reset_vals("rst_in_solve");
        @(posedge clk);
        tick();
        rst = 0;
        tick();
        check_reset_vals("after_rst_solve");

        check("writes_pending", exp_q.size(), 0);
        check("start_pulses", starts_seen, starts_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
